// File: rtl/arm_pkg.sv
// Shared ARM core types: ALU command encodings, NZCV flags, datapath width.
// No logic; types only.
// Imported by the ID/EX boundary and by the EX-stage ALU.
package arm_pkg;

  localparam int DATA_W = 32;

  // ALU command field. Values outside this list are treated as NOP by the ALU.
  typedef enum logic [3:0] {
    EXE_NOP = 4'b0000,
    EXE_MOV = 4'b0001,
    EXE_ADD = 4'b0010,
    EXE_ADC = 4'b0011,
    EXE_SUB = 4'b0100,
    EXE_SBC = 4'b0101,
    EXE_AND = 4'b0110,
    EXE_ORR = 4'b0111,
    EXE_EOR = 4'b1000,
    EXE_MVN = 4'b1001
  } exe_cmd_t;

  // Architectural condition flags, MSB first as in the CPSR.
  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

  // True for any command the ALU actually executes.
  function automatic logic is_alu_op(input exe_cmd_t cmd);
    return (cmd >= EXE_MOV) && (cmd <= EXE_MVN);
  endfunction

endpackage

// File: rtl/id_exe_reg_if.sv
// ID/EX boundary bundle: decoded ID fields in, registered EX fields and flags out.
// No logic; wiring only.
// Hazard control is freeze/flush; there is no valid/ready handshake on this boundary.
interface id_exe_reg_if #(
  parameter int DATA_W = arm_pkg::DATA_W
);

  // Hazard control and ALU flag result
  logic                 freeze;
  logic                 flush;
  arm_pkg::nzcv_t       alu_status;

  // ID-stage fields
  logic                 id_valid;
  logic [DATA_W-1:0]    id_pc;
  arm_pkg::exe_cmd_t    id_exe_cmd;
  logic                 id_mem_r;
  logic                 id_mem_w;
  logic                 id_wb_en;
  logic                 id_b;
  logic                 id_s;
  logic                 id_imm;
  logic [DATA_W-1:0]    id_val_rn;
  logic [DATA_W-1:0]    id_val_rm;
  logic [11:0]          id_shift_op;
  logic [23:0]          id_simm24;
  logic [3:0]           id_dest;
  logic [3:0]           id_src1;
  logic [3:0]           id_src2;

  // EX-stage registered copies
  logic                 ex_valid;
  logic [DATA_W-1:0]    ex_pc;
  arm_pkg::exe_cmd_t    ex_exe_cmd;
  logic                 ex_mem_r;
  logic                 ex_mem_w;
  logic                 ex_wb_en;
  logic                 ex_b;
  logic                 ex_s;
  logic                 ex_imm;
  logic [DATA_W-1:0]    ex_val_rn;
  logic [DATA_W-1:0]    ex_val_rm;
  logic [11:0]          ex_shift_op;
  logic [23:0]          ex_simm24;
  logic [3:0]           ex_dest;
  logic [3:0]           ex_src1;
  logic [3:0]           ex_src2;

  // Flags
  arm_pkg::nzcv_t       status_q;
  arm_pkg::nzcv_t       status_fwd;

  // Pipeline control / ID side
  modport master (
    output freeze, flush, alu_status,
    output id_valid, id_pc, id_exe_cmd, id_mem_r, id_mem_w, id_wb_en, id_b, id_s,
           id_imm, id_val_rn, id_val_rm, id_shift_op, id_simm24, id_dest, id_src1, id_src2,
    input  ex_valid, ex_pc, ex_exe_cmd, ex_mem_r, ex_mem_w, ex_wb_en, ex_b, ex_s,
           ex_imm, ex_val_rn, ex_val_rm, ex_shift_op, ex_simm24, ex_dest, ex_src1, ex_src2,
    input  status_q, status_fwd
  );

  // The ID/EX register itself
  modport slave (
    input  freeze, flush, alu_status,
    input  id_valid, id_pc, id_exe_cmd, id_mem_r, id_mem_w, id_wb_en, id_b, id_s,
           id_imm, id_val_rn, id_val_rm, id_shift_op, id_simm24, id_dest, id_src1, id_src2,
    output ex_valid, ex_pc, ex_exe_cmd, ex_mem_r, ex_mem_w, ex_wb_en, ex_b, ex_s,
           ex_imm, ex_val_rn, ex_val_rm, ex_shift_op, ex_simm24, ex_dest, ex_src1, ex_src2,
    output status_q, status_fwd
  );

endinterface

// File: rtl/status_reg.sv
// Architectural NZCV register plus the forwarded view used by ID condition checks.
// Latency: status_q 1 cycle after load; status_fwd combinational (0 cycles).
// No backpressure; the caller gates ld_en (stall/valid qualification).
module status_reg
  import arm_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  ld_en,
  input  logic  fwd_sel,
  input  nzcv_t alu_status,
  output nzcv_t status_q,
  output nzcv_t status_fwd
);

  nzcv_t flags_q;

  // Flag register: synchronous active-low clear, load on qualified S-instruction.
  always_ff @(posedge clk) begin
    if (!rst) begin
      flags_q <= '0;
    end else if (ld_en) begin
      flags_q <= alu_status;
    end
  end

  // ID sees the flags the EX instruction is about to commit, removing the flag hazard.
  always_comb begin
    status_fwd = flags_q;
    if (fwd_sel) begin
      status_fwd = alu_status;
    end
  end

  assign status_q = flags_q;

endmodule

// File: rtl/id_exe_reg.sv
// ID/EX pipeline register of the ARM core; also owns the NZCV status register.
// Latency: 1 cycle ID to EX; status_fwd is combinational.
// Backpressure: freeze holds all contents; flush loads a bubble and overrides freeze.
module id_exe_reg
  import arm_pkg::*;
#(
  parameter int DATA_W = arm_pkg::DATA_W
) (
  input  logic          clk,
  input  logic          rst,
  id_exe_reg_if.slave   bus
);

  logic              valid_q;
  logic [DATA_W-1:0] pc_q;
  exe_cmd_t          exe_cmd_q;
  logic              mem_r_q;
  logic              mem_w_q;
  logic              wb_en_q;
  logic              b_q;
  logic              s_q;
  logic              imm_q;
  logic [DATA_W-1:0] val_rn_q;
  logic [DATA_W-1:0] val_rm_q;
  logic [11:0]       shift_op_q;
  logic [23:0]       simm24_q;
  logic [3:0]        dest_q;
  logic [3:0]        src1_q;
  logic [3:0]        src2_q;

  logic load_bubble;
  logic ctrl_en;
  logic status_ld;
  logic status_sel;

  // Reset and flush both produce an all-zero bubble; reset additionally clears flags.
  assign load_bubble = !rst || bus.flush;

  // An instruction that failed its condition check still flows, but can have no side effects.
  assign ctrl_en = bus.id_valid;

  // Pipeline register: bubble, hold on stall, else capture ID.
  always_ff @(posedge clk) begin
    if (load_bubble) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      exe_cmd_q  <= EXE_NOP;
      mem_r_q    <= 1'b0;
      mem_w_q    <= 1'b0;
      wb_en_q    <= 1'b0;
      b_q        <= 1'b0;
      s_q        <= 1'b0;
      imm_q      <= 1'b0;
      val_rn_q   <= '0;
      val_rm_q   <= '0;
      shift_op_q <= '0;
      simm24_q   <= '0;
      dest_q     <= '0;
      src1_q     <= '0;
      src2_q     <= '0;
    end else if (!bus.freeze) begin
      valid_q    <= bus.id_valid;
      pc_q       <= bus.id_pc;
      exe_cmd_q  <= bus.id_exe_cmd;
      mem_r_q    <= bus.id_mem_r  & ctrl_en;
      mem_w_q    <= bus.id_mem_w  & ctrl_en;
      wb_en_q    <= bus.id_wb_en  & ctrl_en;
      b_q        <= bus.id_b      & ctrl_en;
      s_q        <= bus.id_s      & ctrl_en;
      imm_q      <= bus.id_imm;
      val_rn_q   <= bus.id_val_rn;
      val_rm_q   <= bus.id_val_rm;
      shift_op_q <= bus.id_shift_op;
      simm24_q   <= bus.id_simm24;
      dest_q     <= bus.id_dest;
      src1_q     <= bus.id_src1;
      src2_q     <= bus.id_src2;
    end
  end

  // The S-instruction in EX forwards its flags to ID and commits them.
  // A stall keeps it in EX, so the commit waits for the first unstalled edge and happens once.
  // Flush overrides freeze: the instruction in EX is the older one and must not lose its flags,
  // and after the flush EX holds a bubble so there is no second commit.
  assign status_sel = valid_q & s_q;
  assign status_ld  = status_sel & (~bus.freeze | bus.flush);

  status_reg u_status_reg (
    .clk        (clk),
    .rst        (rst),
    .ld_en      (status_ld),
    .fwd_sel    (status_sel),
    .alu_status (bus.alu_status),
    .status_q   (bus.status_q),
    .status_fwd (bus.status_fwd)
  );

  assign bus.ex_valid    = valid_q;
  assign bus.ex_pc       = pc_q;
  assign bus.ex_exe_cmd  = exe_cmd_q;
  assign bus.ex_mem_r    = mem_r_q;
  assign bus.ex_mem_w    = mem_w_q;
  assign bus.ex_wb_en    = wb_en_q;
  assign bus.ex_b        = b_q;
  assign bus.ex_s        = s_q;
  assign bus.ex_imm      = imm_q;
  assign bus.ex_val_rn   = val_rn_q;
  assign bus.ex_val_rm   = val_rm_q;
  assign bus.ex_shift_op = shift_op_q;
  assign bus.ex_simm24   = simm24_q;
  assign bus.ex_dest     = dest_q;
  assign bus.ex_src1     = src1_q;
  assign bus.ex_src2     = src2_q;

endmodule

// File: tb/tb_id_exe_reg.sv
// Bench for the ID/EX boundary: directed scenarios followed by randomized traffic,
// all compared against a cycle-level behavioural model of the stage contents and flags.
module tb_id_exe_reg;
  import arm_pkg::*;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [3:0]  cmd;
    logic        mem_r;
    logic        mem_w;
    logic        wb_en;
    logic        b;
    logic        s;
    logic        imm;
    logic [31:0] rn;
    logic [31:0] rm;
    logic [11:0] sh;
    logic [23:0] simm;
    logic [3:0]  dest;
    logic [3:0]  src1;
    logic [3:0]  src2;
  } ex_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  id_exe_reg_if #(.DATA_W(32)) bus ();

  id_exe_reg #(.DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Model state: what EX should hold and what the architectural flags should be.
  ex_t         m_ex;
  logic [3:0]  m_st;
  logic [31:0] pc_mark;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic ex_t obs_ex();
    return {bus.ex_valid, bus.ex_pc, bus.ex_exe_cmd, bus.ex_mem_r, bus.ex_mem_w, bus.ex_wb_en,
            bus.ex_b, bus.ex_s, bus.ex_imm, bus.ex_val_rn, bus.ex_val_rm, bus.ex_shift_op,
            bus.ex_simm24, bus.ex_dest, bus.ex_src1, bus.ex_src2};
  endfunction

  function automatic ex_t id_word();
    return {bus.id_valid, bus.id_pc, bus.id_exe_cmd, bus.id_mem_r, bus.id_mem_w, bus.id_wb_en,
            bus.id_b, bus.id_s, bus.id_imm, bus.id_val_rn, bus.id_val_rm, bus.id_shift_op,
            bus.id_simm24, bus.id_dest, bus.id_src1, bus.id_src2};
  endfunction

  task automatic rand_id();
    bus.id_valid    = 1'($urandom);
    bus.id_pc       = $urandom;
    bus.id_exe_cmd  = exe_cmd_t'(4'($urandom));
    bus.id_mem_r    = 1'($urandom);
    bus.id_mem_w    = 1'($urandom);
    bus.id_wb_en    = 1'($urandom);
    bus.id_b        = 1'($urandom);
    bus.id_s        = 1'($urandom);
    bus.id_imm      = 1'($urandom);
    bus.id_val_rn   = $urandom;
    bus.id_val_rm   = $urandom;
    bus.id_shift_op = 12'($urandom);
    bus.id_simm24   = 24'($urandom);
    bus.id_dest     = 4'($urandom);
    bus.id_src1     = 4'($urandom);
    bus.id_src2     = 4'($urandom);
  endtask

  // Random instruction with the fields that matter for a scenario pinned.
  task automatic set_id(input logic v, input exe_cmd_t c, input logic s);
    rand_id();
    bus.id_valid   = v;
    bus.id_exe_cmd = c;
    bus.id_s       = s;
    bus.id_wb_en   = 1'b1;
    bus.id_mem_r   = 1'b0;
    bus.id_mem_w   = 1'b0;
    bus.id_b       = 1'b0;
  endtask

  // One clock: predict from the rules, then compare every output #1 after the edge.
  task automatic cycle();
    ex_t        n_ex;
    logic [3:0] n_st;
    logic       in_ex_s;
    in_ex_s = m_ex.valid && m_ex.s;
    if (!rst || bus.flush) begin
      n_ex = '0;
    end else if (bus.freeze) begin
      n_ex = m_ex;
    end else begin
      n_ex = id_word();
      if (!bus.id_valid) begin
        n_ex.mem_r = 1'b0;
        n_ex.mem_w = 1'b0;
        n_ex.wb_en = 1'b0;
        n_ex.b     = 1'b0;
        n_ex.s     = 1'b0;
      end
    end
    if (!rst)
      n_st = 4'b0000;
    else if (in_ex_s && (!bus.freeze || bus.flush))
      n_st = bus.alu_status;
    else
      n_st = m_st;
    @(posedge clk);
    #1;
    m_ex = n_ex;
    m_st = n_st;
    chk("ex_bundle", obs_ex(), m_ex);
    chk("status_q", bus.status_q, m_st);
    chk("status_fwd", bus.status_fwd, (m_ex.valid && m_ex.s) ? bus.alu_status : m_st);
  endtask

  initial begin
    m_ex = '0;
    m_st = 4'b0000;
    bus.freeze     = 1'b0;
    bus.flush      = 1'b0;
    bus.alu_status = 4'($urandom);
    rand_id();

    // Reset held for two cycles with random ID traffic
    rst = 1'b0;
    repeat (2) begin
      rand_id();
      bus.alu_status = 4'($urandom);
      cycle();
    end
    chk("rst_ex_zero", obs_ex(), '0);
    chk("rst_status_q", bus.status_q, 4'b0000);

    // Release: ADD with Rn=5 appears in EX one cycle later
    rst = 1'b1;
    set_id(1'b1, EXE_ADD, 1'b0);
    bus.id_val_rn = 32'd5;
    cycle();
    chk("rel_cmd", bus.ex_exe_cmd, 4'b0010);
    chk("rel_rn", bus.ex_val_rn, 32'd5);

    // Flag commit: S-ADD in EX, forwarded same cycle, committed next
    set_id(1'b1, EXE_ADD, 1'b1);
    cycle();
    bus.alu_status = 4'b0110;
    set_id(1'b1, EXE_MOV, 1'b0);
    #1;
    chk("fwd_same_cycle", bus.status_fwd, 4'b0110);
    cycle();
    chk("commit_q", bus.status_q, 4'b0110);
    bus.alu_status = 4'b1111;
    set_id(1'b1, EXE_MOV, 1'b0);
    cycle();
    chk("mov_keeps_q", bus.status_q, 4'b0110);

    // Freeze for 3 cycles with S-SUB in EX
    set_id(1'b1, EXE_SUB, 1'b1);
    pc_mark = bus.id_pc;
    cycle();
    bus.alu_status = 4'b1000;
    bus.freeze     = 1'b1;
    repeat (3) begin
      rand_id();
      cycle();
      chk("frz_cmd", bus.ex_exe_cmd, 4'b0100);
      chk("frz_pc", bus.ex_pc, pc_mark);
      chk("frz_s", bus.ex_s, 1'b1);
      chk("frz_q", bus.status_q, 4'b0110);
    end
    bus.freeze = 1'b0;
    set_id(1'b1, EXE_MOV, 1'b0);
    cycle();
    chk("unfrz_commit", bus.status_q, 4'b1000);
    bus.alu_status = 4'b0001;
    set_id(1'b1, EXE_MOV, 1'b0);
    cycle();
    chk("commit_once", bus.status_q, 4'b1000);

    // Flush and freeze together: bubble wins, EX S-instruction still commits
    set_id(1'b1, EXE_ADD, 1'b1);
    cycle();
    bus.alu_status = 4'b0011;
    bus.flush      = 1'b1;
    bus.freeze     = 1'b1;
    set_id(1'b1, EXE_ADD, 1'b1);
    cycle();
    chk("flfz_valid", bus.ex_valid, 1'b0);
    chk("flfz_wb_en", bus.ex_wb_en, 1'b0);
    chk("flfz_commit", bus.status_q, 4'b0011);
    bus.flush  = 1'b0;
    bus.freeze = 1'b0;

    // Instruction that failed its condition check
    set_id(1'b0, EXE_ADD, 1'b1);
    bus.id_mem_w = 1'b1;
    cycle();
    chk("inv_wb_en", bus.ex_wb_en, 1'b0);
    chk("inv_mem_w", bus.ex_mem_w, 1'b0);
    chk("inv_valid", bus.ex_valid, 1'b0);

    // Reset mid-stream with S-ADC in EX and flags all set
    set_id(1'b1, EXE_ADC, 1'b1);
    cycle();
    bus.alu_status = 4'b1111;
    set_id(1'b1, EXE_ADC, 1'b1);
    cycle();
    chk("pre_rst_q", bus.status_q, 4'b1111);
    rst = 1'b0;
    cycle();
    chk("mid_rst_q", bus.status_q, 4'b0000);
    chk("mid_rst_fwd", bus.status_fwd, 4'b0000);

    // Randomized traffic with occasional stall, flush and reset
    for (int i = 0; i < 400; i++) begin
      rand_id();
      bus.alu_status = 4'($urandom);
      bus.freeze     = ($urandom_range(0, 3) == 0);
      bus.flush      = ($urandom_range(0, 7) == 0);
      rst            = ($urandom_range(0, 31) != 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
